// File: rtl/synth_audio_pkg.sv
// Shared audio-path constants: sample width, envelope amplitude width and the
// gain code that means "pass the sample through unscaled".
package synth_audio_pkg;
  localparam int ENV_AMP_W = 6;
  localparam int SAMPLE_W  = 24;
  localparam int AMP_W     = ENV_AMP_W;
  localparam int AMP_UNITY = (1 << AMP_W) - 1;
  localparam int SLEW_STEP = 1;
endpackage

// File: rtl/amp_slew.sv
// Slew-limited gain register: on each enabled cycle the applied gain moves
// towards the envelope target by at most SLEW_STEP, never overshooting.
module amp_slew
  import synth_audio_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic [AMP_W-1:0] amp_target,
  output logic [AMP_W-1:0] amp_cur
);
  localparam logic [AMP_W:0]   STEP_WIDE = (AMP_W+1)'(SLEW_STEP);
  localparam logic [AMP_W-1:0] STEP_N    = STEP_WIDE[AMP_W-1:0];

  logic [AMP_W-1:0] amp_cur_q, amp_cur_d;
  logic [AMP_W-1:0] diff_up, diff_dn;

  assign diff_up = amp_target - amp_cur_q;
  assign diff_dn = amp_cur_q - amp_target;

  always_comb begin
    amp_cur_d = amp_cur_q;
    if (step_en) begin
      // Diffs are only meaningful on the side of the matching comparison.
      if (amp_target > amp_cur_q) begin
        amp_cur_d = ({1'b0, diff_up} > STEP_WIDE) ? amp_cur_q + STEP_N : amp_target;
      end else if (amp_target < amp_cur_q) begin
        amp_cur_d = ({1'b0, diff_dn} > STEP_WIDE) ? amp_cur_q - STEP_N : amp_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) amp_cur_q <= '0;
    else        amp_cur_q <= amp_cur_d;
  end

  assign amp_cur = amp_cur_q;
endmodule

// File: rtl/envelope_vca.sv
// Two-stage VCA: S1 holds a sample with the gain it was accepted under,
// S2 holds the rounded product. Valid/ready: a transfer happens when both are high.
module envelope_vca
  import synth_audio_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AMP_W-1:0]           amp_target,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] out_sample,
  input  logic                       out_ready,
  output logic                       idle
);
  localparam int PROD_W = SAMPLE_W + AMP_W + 1;
  localparam logic [AMP_W-1:0]         UNITY_G = AMP_W'(AMP_UNITY);
  localparam logic signed [PROD_W-1:0] ROUND_C = PROD_W'(1 << (AMP_W - 1));

  logic                       s1_valid_q, s1_valid_d;
  logic signed [SAMPLE_W-1:0] s1_sample_q, s1_sample_d;
  logic [AMP_W-1:0]           s1_gain_q, s1_gain_d;
  logic                       s2_valid_q, s2_valid_d;
  logic signed [SAMPLE_W-1:0] s2_sample_q, s2_sample_d;

  logic                       s1_adv, in_hs;
  logic [AMP_W-1:0]           amp_cur;
  logic signed [PROD_W-1:0]   prod, rounded;
  logic signed [SAMPLE_W-1:0] scaled;

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_hs    = in_valid && in_ready;

  amp_slew u_slew (
    .clk        (clk),
    .reset      (reset),
    .step_en    (in_hs),
    .amp_target (amp_target),
    .amp_cur    (amp_cur)
  );

  // Gain is zero-extended so code 62 stays positive; unity code bypasses scaling.
  assign prod    = s1_sample_q * $signed({1'b0, s1_gain_q});
  assign rounded = prod + ROUND_C;
  assign scaled  = (s1_gain_q == UNITY_G) ? s1_sample_q : SAMPLE_W'(rounded >>> AMP_W);

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sample_d = s1_sample_q;
    s1_gain_d   = s1_gain_q;
    s2_valid_d  = s2_valid_q;
    s2_sample_d = s2_sample_q;
    if (in_ready) s1_valid_d = in_valid;
    if (in_hs) begin
      s1_sample_d = in_sample;
      s1_gain_d   = amp_cur;
    end
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_sample_d = scaled;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_sample_q <= '0;
      s1_gain_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_sample_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sample_q <= s1_sample_d;
      s1_gain_q   <= s1_gain_d;
      s2_valid_q  <= s2_valid_d;
      s2_sample_q <= s2_sample_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_sample = s2_sample_q;
  assign idle       = (amp_cur == '0) && (amp_target == '0) && !s1_valid_q && !s2_valid_q;
endmodule

// File: tb/tb_envelope_vca.sv
// Directed bench for envelope_vca with a transaction-level reference model
// and a per-cycle compare process.
module tb_envelope_vca;
  import synth_audio_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [AMP_W-1:0]           amp_target;
  logic                       in_valid;
  logic signed [SAMPLE_W-1:0] in_sample;
  logic                       in_ready;
  logic                       out_valid;
  logic signed [SAMPLE_W-1:0] out_sample;
  logic                       out_ready;
  logic                       idle;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int model_amp = 0;
  int first_valid_cyc = -1;
  int cnt;

  logic [SAMPLE_W-1:0] exp_q[$];
  int                  acc_q[$];
  int                  acc_log[$];
  longint              out_log[$];

  always #5 clk = ~clk;

  envelope_vca dut (
    .clk        (clk),
    .reset      (reset),
    .amp_target (amp_target),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .out_ready  (out_ready),
    .idle       (idle)
  );

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference arithmetic: unity passes through, else floor((s*g + half) / 2^AMP_W).
  function automatic longint vca_ref(longint s, int g);
    if (g == AMP_UNITY) return s;
    return (s * g + (1 << (AMP_W - 1))) >>> AMP_W;
  endfunction

  function automatic int slew(int cur, int tgt);
    if (tgt > cur) return cur + ((tgt - cur) < SLEW_STEP ? (tgt - cur) : SLEW_STEP);
    if (tgt < cur) return cur - ((cur - tgt) < SLEW_STEP ? (cur - tgt) : SLEW_STEP);
    return cur;
  endfunction

  // Transaction monitor: records handshakes and advances the model.
  always @(posedge clk) begin
    if (!reset) begin
      exp_q.delete();
      acc_q.delete();
      model_amp = 0;
    end else begin
      if (out_valid && out_ready) begin
        out_log.push_back(out_sample);
        if (exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(SAMPLE_W'(vca_ref(in_sample, model_amp)));
        acc_q.push_back(cyc);
        acc_log.push_back(cyc);
        model_amp = slew(model_amp, amp_target);
      end
    end
    cyc++;
  end

  // Compare process: in-flight count, head age and model gain define every output.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
      check("out_valid", out_valid, (exp_q.size() > 0) && (cyc - acc_q[0] >= 2));
      if (out_valid && exp_q.size() > 0)
        check("out_sample", out_sample, $signed(exp_q[0]));
      check("idle", idle, (model_amp == 0) && (amp_target == 0) && (exp_q.size() == 0));
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int n, longint s, bit gap);
    int got;
    got = 0;
    in_sample = SAMPLE_W'(s);
    for (int c = 0; c < 4000 && got < n; c++) begin
      in_valid = gap ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) got++;
      tick();
    end
    in_valid = 1'b0;
    check("send_count", got, n);
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    amp_target = '0;
    in_valid = 1'b0;
    in_sample = '0;
    out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_out_sample", out_sample, 0);
    tick();
    reset = 1'b1;
    tick();

    // Ramp from zero gain towards 32 with a steady stream.
    out_log.delete(); acc_log.delete(); first_valid_cyc = -1;
    amp_target = 6'd32;
    send(40, 1000, 1'b0);
    drain();
    check("t1_count", out_log.size(), 40);
    check("t1_first", out_log[0], 0);
    check("t1_second", out_log[1], 16);
    check("t1_third", out_log[2], 31);
    check("t1_settled", out_log[32], 500);
    check("t1_last", out_log[39], 500);
    check("t1_latency", first_valid_cyc - acc_log[0], 2);

    // Rounding at gain 32.
    out_log.delete();
    send(1, -3, 1'b0);
    send(1, 3, 1'b0);
    send(1, 1, 1'b0);
    drain();
    check("t3_neg3", out_log[0], -1);
    check("t3_pos3", out_log[1], 2);
    check("t3_pos1", out_log[2], 1);

    // Backpressure: two slots fill, then input stalls with output held.
    out_log.delete();
    out_ready = 1'b0;
    in_valid = 1'b1;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      in_sample = SAMPLE_W'(cnt + 1);
      @(negedge clk);
      if (in_ready) cnt++;
      tick();
    end
    in_valid = 1'b0;
    check("t4_accepted", cnt, 2);
    @(negedge clk);
    check("t4_stall_ready", in_ready, 0);
    check("t4_stall_sample", out_sample, 1);
    tick();
    out_ready = 1'b1;
    send(1, 3, 1'b0);
    drain();
    check("t4_count", out_log.size(), 3);
    check("t4_o0", out_log[0], 1);
    check("t4_o1", out_log[1], 1);
    check("t4_o2", out_log[2], 2);

    // Full scale negative: ramp to unity, then decay to zero.
    out_log.delete();
    amp_target = 6'd63;
    send(80, -8388608, 1'b0);
    amp_target = 6'd0;
    send(70, -8388608, 1'b0);
    drain();
    check("t2_unity", out_log[79], -8388608);
    check("t2_decay_first", out_log[80], -8388608);
    check("t2_gain62", out_log[81], -8126464);
    check("t2_zero", out_log[149], 0);
    @(negedge clk);
    check("t2_idle", idle, 1);
    tick();

    // Reset with both stages full discards their contents.
    amp_target = 6'd10;
    out_ready = 1'b0;
    send(2, 500, 1'b0);
    out_log.delete();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_idle", idle, 0);
    tick();
    out_ready = 1'b1;
    send(1, 1000, 1'b0);
    drain();
    check("t5_count", out_log.size(), 1);
    check("t5_gain_zero", out_log[0], 0);

    // Gain steps once per accepted sample, not per cycle.
    amp_target = 6'd0;
    send(1, 0, 1'b0);
    drain();
    out_log.delete();
    amp_target = 6'd10;
    send(12, 640, 1'b1);
    drain();
    check("t6_g0", out_log[0], 0);
    check("t6_g1", out_log[1], 10);
    check("t6_g5", out_log[5], 50);
    check("t6_g9", out_log[9], 90);
    check("t6_g10", out_log[10], 100);
    check("t6_hold", out_log[11], 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
